// File: rtl/ahb_pkg.sv
// Bus encodings and slave FSM states, shared by ahb_slave and AHB_master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_t;

endpackage

// File: rtl/ahb_slave_mem.sv
// Word array behind the AHB slave: synchronous write, asynchronous read, cleared on reset.
module ahb_slave_mem #(
  parameter int unsigned MEM_AW = 6
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**MEM_AW];

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave.sv
// AHB-Lite memory responder: wait-state insertion, range/alignment checking,
// two-cycle ERROR response and write-to-read forwarding on pipelined accesses.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no data phase pending
// ST_DATA | legal transfer in data phase, wcnt wait cycles left
// ST_ERR1 | first ERROR cycle, hreadyout low
// ST_ERR2 | second ERROR cycle, hreadyout high
module ahb_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_AW      = 6,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam logic [7:0] WS_INIT = 8'(WAIT_STATES);

  slv_state_t        state;
  logic [7:0]        wcnt;
  logic              write_q;
  logic [MEM_AW-1:0] idx_q;
  logic [MEM_AW-1:0] idx;
  logic              accept;
  logic              legal;
  logic              done;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  assign idx    = haddr[MEM_AW+1:2];
  assign accept = hsel & hready & ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign legal  = (haddr[1:0] == 2'b00) && ((haddr >> (MEM_AW + 2)) == 32'd0);
  // A new address may be taken whenever no data phase is still stalling.
  assign done   = (state == ST_IDLE) || (state == ST_ERR2) ||
                  ((state == ST_DATA) && (wcnt == 8'd0));
  assign mem_we = (state == ST_DATA) && (wcnt == 8'd0) && write_q;

  ahb_slave_mem #(.MEM_AW(MEM_AW)) u_mem (
    .hclk    (hclk),
    .hresetn (hresetn),
    .we      (mem_we),
    .waddr   (idx_q),
    .wdata   (hwdata),
    .raddr   (idx),
    .rdata   (mem_rdata)
  );

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
      wcnt      <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
    end else if (done) begin
      if (accept && legal) begin
        state     <= ST_DATA;
        wcnt      <= WS_INIT;
        hreadyout <= (WS_INIT == 8'd0);
        hresp     <= HRESP_OKAY;
        write_q   <= hwrite;
        idx_q     <= idx;
        // The array has not yet seen a write retiring on this same edge.
        if (!hwrite) hrdata <= (mem_we && (idx_q == idx)) ? hwdata : mem_rdata;
      end else if (accept) begin
        state     <= ST_ERR1;
        wcnt      <= '0;
        hreadyout <= 1'b0;
        hresp     <= HRESP_ERROR;
        write_q   <= 1'b0;
      end else begin
        state     <= ST_IDLE;
        hreadyout <= 1'b1;
        hresp     <= HRESP_OKAY;
        write_q   <= 1'b0;
      end
    end else if (state == ST_ERR1) begin
      state     <= ST_ERR2;
      hreadyout <= 1'b1;
      hresp     <= HRESP_ERROR;
    end else begin
      wcnt      <= wcnt - 8'd1;
      hreadyout <= (wcnt == 8'd1);
    end
  end

endmodule
